systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Operand-side driver for systolic_array; produces exactly the stream a bench hand-feeds it today.
- Buffers an N×N A matrix (row lanes) and an N×N B matrix (column lanes) written one element at a time.
- On start, streams both matrices diagonally skewed into the array's in_left/in_top lanes with en asserted.
- Raises done when the last partial product has reached PE(N-1,N-1).

Parameters:
MATRIX_SIZE, 3, N: array dimension, lanes per side
DATA_WIDTH, 8, element width, matches array DATA_WIDTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
wr_en  in  1  write one matrix element (accepted only when wr_ready=1)
wr_sel  in  1  0 = matrix A, 1 = matrix B
wr_row  in  $clog2(N)  element row index
wr_col  in  $clog2(N)  element column index
wr_data  in  DATA_WIDTH  element value
wr_ready  out  1  high in IDLE only
start  in  1  begin streaming (accepted only in IDLE)
busy  out  1  high in FEED and DONE
done  out  1  one-cycle pulse, last feed cycle complete
en  out  1  drives array en
out_left  out  N*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH] → array in_left_i
out_top  out  N*DATA_WIDTH  lane j at [j*DATA_WIDTH +: DATA_WIDTH] → array in_top_j

Behaviour:
- Reset (rst=0 at edge): state IDLE; A and B cleared to 0; t=0; en=0, done=0, busy=0, wr_ready=1, out_left/out_top=0. Reset wins over every other input, including mid-FEED (stream aborts immediately, no done).
- Storage: two N×N register arrays. Write commits at the edge where wr_en=1 and wr_ready=1. Writes outside IDLE are dropped. Index ≥ N is dropped, no state change.
- FSM IDLE: start=1 → FEED with t=0. Same-edge wr_en and start: the write commits and the feed uses the new value.
- FSM FEED: feed cycle counter t runs 0 .. FEED_LEN-1, where FEED_LEN = 3N-2 (7 for N=3). t has width $clog2(3N-1). At t=FEED_LEN-1 the next state is DONE. start is ignored.
- FSM DONE: lasts one cycle; done=1, en=0, outputs 0; then returns to IDLE.
- Outputs are registered. The first edge after start is accepted presents t=0 values, so en and data align in the same cycle.
- Skew in FEED at cycle t:
  - out_left lane i = A[i][t-i] if 0 ≤ t-i < N, else 0.
  - out_top lane j = B[t-j][j] if 0 ≤ t-j < N, else 0.
  - en=1 for all FEED cycles, including the trailing zero cycles, so the array keeps shifting until PE(N-1,N-1) consumes k=N-1 at t=3N-3.
- en=0 and all lanes 0 in IDLE and DONE.
- Matrix contents persist after DONE; a new start replays them unchanged.
- No arithmetic; pure selection. Index t-i is computed in width $clog2(3N-1)+1 to avoid wrap on the negative case.
- Latency: start edge → done pulse = FEED_LEN+1 cycles (8 for N=3).

Test Plan:
1. Reset values: hold rst=0 for 2 cycles → en=0, done=0, busy=0, wr_ready=1, all lanes 0. Start with no writes → 7 cycles of en=1 with all lanes 0, then done.
2. Skew check: load A=[[1,2,3],[4,5,6],[7,8,9]] and B=I3, pulse start. Over feed t=0..6 the lanes must show:
   - left0: 1,2,3,0,0,0,0
   - left1: 0,4,5,6,0,0,0
   - left2: 0,0,7,8,9,0,0
   - top0: 1,0,0,0,0,0,0
   - top1: 0,0,1,0,0,0,0
   - top2: 0,0,0,0,1,0,0
   - en high exactly 7 cycles; done on cycle 8.
3. End-to-end with systolic_array (array reset first): A as in scenario 2, B=A → acc rows 30 36 42 / 66 81 96 / 102 126 150.
4. Blocked accesses: wr_en and start issued mid-FEED → wr_ready=0, matrices unchanged, stream length still 7, single done.
5. Reset mid-operation: rst=0 at t=3 → next cycle en=0, lanes 0, busy=0, no done. Restart streams zeros since the matrices were cleared.
6. Boundary inputs: out-of-range write (wr_row=3) is ignored. Same-cycle wr_en (A[0][0]=9) and start → left0 first value is 9.

Source files
------------

// File: rtl/systolic_feeder.sv
// Operand feeder for systolic_array: buffers A (row lanes) and B (column lanes),
// then streams both diagonally skewed with en held high for 3N-2 cycles.

// One output lane: picks vec[t - LANE] when that index lies in 0..N-1, else 0.
module systolic_feeder_lane #(
  parameter int N    = 3,
  parameter int DW   = 8,
  parameter int TW   = 3,
  parameter int LANE = 0
) (
  input  logic [TW-1:0]        t,
  input  logic [N-1:0][DW-1:0] vec,
  output logic [DW-1:0]        val
);
  // One extra bit so t < LANE lands far above N-1 instead of wrapping into range
  logic [TW:0] k;
  assign k = {1'b0, t} - (TW+1)'(LANE);

  always_comb begin
    val = '0;
    for (int i = 0; i < N; i++)
      if (k == (TW+1)'(i)) val = vec[i];
  end
endmodule

module systolic_feeder #(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic                              wr_sel,
  input  logic [$clog2(MATRIX_SIZE)-1:0]    wr_row,
  input  logic [$clog2(MATRIX_SIZE)-1:0]    wr_col,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              wr_ready,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              en,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] out_left,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] out_top
);
  localparam int N        = MATRIX_SIZE;
  localparam int DW       = DATA_WIDTH;
  localparam int FEED_LEN = 3*N - 2;
  localparam int TW       = $clog2(3*N - 1);

  typedef enum logic [1:0] {IDLE, FEED, DONE} state_t;

  state_t                       state_q, state_nxt;
  logic [TW-1:0]                t_q, t_nxt;
  logic [N-1:0][N-1:0][DW-1:0]  a_q, a_nxt, b_q, b_nxt;
  logic [N-1:0][N-1:0][DW-1:0]  b_col;
  logic [N-1:0][DW-1:0]         left_q, left_nxt, top_q, top_nxt;

  always_comb begin
    state_nxt = state_q;
    t_nxt     = '0;
    a_nxt     = a_q;
    b_nxt     = b_q;
    case (state_q)
      IDLE: begin
        if (wr_en && int'(wr_row) < N && int'(wr_col) < N) begin
          if (wr_sel) b_nxt[wr_row][wr_col] = wr_data;
          else        a_nxt[wr_row][wr_col] = wr_data;
        end
        if (start) state_nxt = FEED;
      end
      FEED: begin
        if (t_q == TW'(FEED_LEN - 1)) state_nxt = DONE;
        else                           t_nxt     = t_q + 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lanes select from the post-write matrices so a write on the start edge is fed
  genvar gi, gk;
  generate
    for (gi = 0; gi < N; gi++) begin : g_col
      for (gk = 0; gk < N; gk++) begin : g_k
        assign b_col[gi][gk] = b_nxt[gk][gi];
      end
    end
    for (gi = 0; gi < N; gi++) begin : g_lane
      systolic_feeder_lane #(.N(N), .DW(DW), .TW(TW), .LANE(gi)) u_left (
        .t(t_nxt), .vec(a_nxt[gi]), .val(left_nxt[gi])
      );
      systolic_feeder_lane #(.N(N), .DW(DW), .TW(TW), .LANE(gi)) u_top (
        .t(t_nxt), .vec(b_col[gi]), .val(top_nxt[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      left_q  <= '0;
      top_q   <= '0;
    end else begin
      state_q <= state_nxt;
      t_q     <= t_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      left_q  <= (state_nxt == FEED) ? left_nxt : '0;
      top_q   <= (state_nxt == FEED) ? top_nxt  : '0;
    end
  end

  assign wr_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign en       = (state_q == FEED);
  assign done     = (state_q == DONE);
  assign out_left = left_q;
  assign out_top  = top_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed + randomized bench for systolic_feeder against a matrix-level reference model.
module tb_systolic_feeder;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int FL = 3*N - 2;

  logic              clk = 0;
  logic              rst = 0;
  logic              wr_en = 0, wr_sel = 0, start = 0;
  logic [1:0]        wr_row = 0, wr_col = 0;
  logic [DW-1:0]     wr_data = 0;
  logic              wr_ready, busy, done, en;
  logic [N*DW-1:0]   out_left, out_top;

  int checks = 0;
  int errors = 0;
  int am [N][N];
  int bm [N][N];
  int cap_l [FL][N];
  int cap_t [FL][N];
  int tbl_l [N][FL] = '{'{1,2,3,0,0,0,0}, '{0,4,5,6,0,0,0}, '{0,0,7,8,9,0,0}};
  int tbl_t [N][FL] = '{'{1,0,0,0,0,0,0}, '{0,0,1,0,0,0,0}, '{0,0,0,0,1,0,0}};
  int prod3 [N][N]  = '{'{30,36,42}, '{66,81,96}, '{102,126,150}};

  systolic_feeder #(.MATRIX_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .wr_ready(wr_ready), .start(start),
    .busy(busy), .done(done), .en(en), .out_left(out_left), .out_top(out_top)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin am[i][j] = 0; bm[i][j] = 0; end
  endtask

  // Expected lane words straight from the skew rule: lane i carries element k = t - i
  task automatic exp_lanes(input int t, output logic [N*DW-1:0] el, output logic [N*DW-1:0] et);
    el = '0; et = '0;
    for (int i = 0; i < N; i++) begin
      if (t - i >= 0 && t - i < N) begin
        el[i*DW +: DW] = DW'(am[i][t-i]);
        et[i*DW +: DW] = DW'(bm[t-i][i]);
      end
    end
  endtask

  task automatic wr(input logic sel, input int row, input int col, input int data);
    wr_en = 1; wr_sel = sel; wr_row = 2'(row); wr_col = 2'(col); wr_data = DW'(data);
    @(posedge clk); #1;
    wr_en = 0;
    if (row < N && col < N) begin
      if (sel) bm[row][col] = data & 8'hFF;
      else     am[row][col] = data & 8'hFF;
    end
  endtask

  // Runs one start; inj_t injects a write+start mid-stream, rst_t pulls reset at that feed cycle
  task automatic feed(input string tag, input int inj_t, input int rst_t);
    logic [N*DW-1:0] el, et;
    start = 1;
    @(posedge clk); #1;
    start = 0; wr_en = 0;
    for (int t = 0; t < FL; t++) begin
      exp_lanes(t, el, et);
      chk({tag, ".en"}, 64'(en), 1);
      chk({tag, ".busy"}, 64'(busy), 1);
      chk({tag, ".wr_ready"}, 64'(wr_ready), 0);
      chk({tag, ".done_early"}, 64'(done), 0);
      chk($sformatf("%s.left_t%0d", tag, t), 64'(out_left), 64'(el));
      chk($sformatf("%s.top_t%0d", tag, t), 64'(out_top), 64'(et));
      for (int i = 0; i < N; i++) begin
        cap_l[t][i] = int'(out_left[i*DW +: DW]);
        cap_t[t][i] = int'(out_top[i*DW +: DW]);
      end
      if (t == inj_t) begin
        wr_en = 1; wr_sel = 0; wr_row = 0; wr_col = 0; wr_data = 8'hEE; start = 1;
      end
      if (t == rst_t) begin
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
        clear_model();
        chk({tag, ".rst_en"}, 64'(en), 0);
        chk({tag, ".rst_busy"}, 64'(busy), 0);
        chk({tag, ".rst_done"}, 64'(done), 0);
        chk({tag, ".rst_left"}, 64'(out_left), 0);
        chk({tag, ".rst_top"}, 64'(out_top), 0);
        @(posedge clk); #1;
        chk({tag, ".rst_no_done"}, 64'(done), 0);
        return;
      end
      @(posedge clk); #1;
      wr_en = 0; start = 0;
    end
    chk({tag, ".done"}, 64'(done), 1);
    chk({tag, ".done_en"}, 64'(en), 0);
    chk({tag, ".done_left"}, 64'(out_left), 0);
    chk({tag, ".done_top"}, 64'(out_top), 0);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 64'(done), 0);
    chk({tag, ".idle_busy"}, 64'(busy), 0);
    chk({tag, ".idle_ready"}, 64'(wr_ready), 1);
  endtask

  function automatic int capv(input bit top, input int t, input int lane);
    if (t < 0 || t >= FL) return 0;
    return top ? cap_t[t][lane] : cap_l[t][lane];
  endfunction

  // PE(i,j) sees left lane i delayed j cycles and top lane j delayed i cycles
  task automatic prod_check(input string tag, input bit use_tbl);
    int s, e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0; e = 0;
        for (int t = 0; t < FL + 2*N; t++) s += capv(0, t - j, i) * capv(1, t - i, j);
        for (int k = 0; k < N; k++) e += am[i][k] * bm[k][j];
        if (use_tbl) e = prod3[i][j];
        chk($sformatf("%s.c%0d%0d", tag, i, j), 64'(s), 64'(e));
      end
  endtask

  initial begin
    clear_model();
    @(posedge clk); @(posedge clk); #1;
    chk("reset.en", 64'(en), 0);
    chk("reset.done", 64'(done), 0);
    chk("reset.busy", 64'(busy), 0);
    chk("reset.wr_ready", 64'(wr_ready), 1);
    chk("reset.left", 64'(out_left), 0);
    chk("reset.top", 64'(out_top), 0);
    rst = 1;
    feed("zeros", -1, -1);

    // Skew against the literal lane table, B = identity
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        wr(0, i, j, i*N + j + 1);
        wr(1, i, j, (i == j) ? 1 : 0);
      end
    feed("skew", -1, -1);
    for (int t = 0; t < FL; t++)
      for (int i = 0; i < N; i++) begin
        chk($sformatf("tbl.l%0d_t%0d", i, t), 64'(cap_l[t][i]), 64'(tbl_l[i][t]));
        chk($sformatf("tbl.t%0d_t%0d", i, t), 64'(cap_t[t][i]), 64'(tbl_t[i][t]));
      end

    // B = A, product against the known result
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wr(1, i, j, i*N + j + 1);
    feed("e2e", -1, -1);
    prod_check("e2e", 1);

    // Write and start issued mid-stream are dropped; replay unchanged
    feed("blocked", 2, -1);
    feed("replay", -1, -1);
    prod_check("replay", 0);

    // Randomized matrices
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          wr(0, i, j, int'($urandom_range(0, 255)));
          wr(1, i, j, int'($urandom_range(0, 255)));
        end
      feed($sformatf("rand%0d", r), -1, -1);
      prod_check($sformatf("rand%0d", r), 0);
    end

    // Reset mid-feed clears matrices; restart streams zeros
    feed("midrst", -1, 3);
    feed("after_rst", -1, -1);

    // Out-of-range writes are ignored
    wr(0, 3, 0, 55);
    wr(1, 0, 3, 66);
    feed("oob", -1, -1);

    // Write on the start edge feeds the new value
    wr_en = 1; wr_sel = 0; wr_row = 0; wr_col = 0; wr_data = 8'd9;
    am[0][0] = 9;
    feed("same_edge", -1, -1);
    chk("same_edge.left0_first", 64'(cap_l[0][0]), 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
